// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Producer-side hazard control for the RV32IM 5-stage pipeline. It tracks
//   the destination tag of every in-flight instruction in EX/MEM/WB, exports
//   those tags to the forwarding logic, raises load-use and multicycle divide
//   stalls, and inserts bubbles into ID/EX.
//
//   Parameters:
//     DIV_CYCLES     cycles a DIV/DIVU/REM/REMU occupies EX (2..63)
//
//   Ports:
//     CLK                 pipeline clock
//     RESET               synchronous, active-low reset
//     ID_INSTRUCTION      instruction currently in ID
//     ID_VALID            ID holds a real instruction
//     FLUSH               taken branch/jump in EX; kills the ID instruction
//     STALL               hold PC and IF/ID
//     BUBBLE_EX           load NOP into ID/EX this edge
//     EX_HOLD             hold ID/EX contents (divide in progress)
//     DIV_BUSY            divider occupying EX
//     EX_RD/MEM_RD/WB_RD  tracked destination tags
//     *_RD_VALID          tag valid (writes rd, rd != x0)
//     EX_IS_LOAD          EX slot holds a load
//
//   Optional build macro HAZARD_PERF_CNT_EN adds:
//     LOAD_STALL_COUNT    count of load-use stall cycles (wraps)
//     DIV_STALL_COUNT     count of EX_HOLD cycles (wraps)

module hazard_stall_unit #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ID_INSTRUCTION,
    input  logic        ID_VALID,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        BUBBLE_EX,
    output logic        EX_HOLD,
    output logic        DIV_BUSY,
    output logic [4:0]  EX_RD,
    output logic [4:0]  MEM_RD,
    output logic [4:0]  WB_RD,
    output logic        EX_RD_VALID,
    output logic        MEM_RD_VALID,
    output logic        WB_RD_VALID,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] LOAD_STALL_COUNT,
    output logic [31:0] DIV_STALL_COUNT,
`endif
    output logic        EX_IS_LOAD
);

    typedef enum logic {ST_IDLE, ST_DIV_BUSY} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       valid;
        logic       is_load;
    } slot_t;

    localparam logic [5:0] DIV_RELOAD = 6'(DIV_CYCLES - 1);

    state_t     state, state_nx;
    logic [5:0] cnt, cnt_nx;
    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_nx, mem_nx, wb_nx;

    logic [6:0] opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       uses_rs1, uses_rs2, writes_rd, is_load_op, is_div;
    logic       load_use;
    slot_t      id_slot;
    logic       issue, flush_ok, load_stall;

    assign opcode = ID_INSTRUCTION[6:0];
    assign id_rd  = ID_INSTRUCTION[11:7];
    assign funct3 = ID_INSTRUCTION[14:12];
    assign id_rs1 = ID_INSTRUCTION[19:15];
    assign id_rs2 = ID_INSTRUCTION[24:20];
    assign funct7 = ID_INSTRUCTION[31:25];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            7'b0010011: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            7'b0000011: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100111: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            7'b1101111: writes_rd = 1'b1;
            7'b0110111: writes_rd = 1'b1;
            7'b0010111: writes_rd = 1'b1;
            default: ;
        endcase
    end

    assign is_load_op = (opcode == 7'b0000011);
    assign is_div     = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && funct3[2];

    // Tag stored as 0 whenever it is not valid, so bubbles and x0 writers look alike.
    always_comb begin
        id_slot         = '0;
        id_slot.valid   = ID_VALID && writes_rd && (id_rd != 5'd0);
        id_slot.rd      = id_slot.valid ? id_rd : 5'd0;
        id_slot.is_load = ID_VALID && is_load_op;
    end

    // x0 sources never match: a valid EX tag is never x0.
    assign load_use = ID_VALID && ex_q.is_load && ex_q.valid &&
                      ((uses_rs1 && (id_rs1 == ex_q.rd)) ||
                       (uses_rs2 && (id_rs2 == ex_q.rd)));

    always_comb begin
        STALL     = 1'b0;
        BUBBLE_EX = 1'b0;
        EX_HOLD   = 1'b0;
        DIV_BUSY  = 1'b0;
        state_nx  = state;
        cnt_nx    = cnt;
        ex_nx     = ex_q;
        mem_nx    = mem_q;
        wb_nx     = wb_q;
        issue     = 1'b0;
        flush_ok  = 1'b0;
        load_stall = 1'b0;

        case (state)
            ST_IDLE: begin
                issue    = 1'b1;
                flush_ok = 1'b1;
            end
            ST_DIV_BUSY: begin
                DIV_BUSY = 1'b1;
                if (cnt != 6'd0) begin
                    STALL   = 1'b1;
                    EX_HOLD = 1'b1;
                    mem_nx  = '0;
                    wb_nx   = mem_q;
                    cnt_nx  = cnt - 6'd1;
                end else begin
                    // Final divide cycle behaves like IDLE, except a younger
                    // branch cannot be in EX, so FLUSH is not honoured.
                    issue = 1'b1;
                end
            end
            default: ;
        endcase

        if (issue) begin
            state_nx = ST_IDLE;
            wb_nx    = mem_q;
            mem_nx   = ex_q;
            if (flush_ok && FLUSH) begin
                BUBBLE_EX = 1'b1;
                ex_nx     = '0;
            end else if (load_use) begin
                STALL      = 1'b1;
                BUBBLE_EX  = 1'b1;
                load_stall = 1'b1;
                ex_nx      = '0;
            end else begin
                ex_nx = id_slot;
                if (ID_VALID && is_div) begin
                    state_nx = ST_DIV_BUSY;
                    cnt_nx   = DIV_RELOAD;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ex_q  <= ex_nx;
            mem_q <= mem_nx;
            wb_q  <= wb_nx;
        end
    end

    assign EX_RD        = ex_q.rd;
    assign MEM_RD       = mem_q.rd;
    assign WB_RD        = wb_q.rd;
    assign EX_RD_VALID  = ex_q.valid;
    assign MEM_RD_VALID = mem_q.valid;
    assign WB_RD_VALID  = wb_q.valid;
    assign EX_IS_LOAD   = ex_q.is_load;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            LOAD_STALL_COUNT <= '0;
            DIV_STALL_COUNT  <= '0;
        end else begin
            if (load_stall) LOAD_STALL_COUNT <= LOAD_STALL_COUNT + 32'd1;
            if (EX_HOLD)    DIV_STALL_COUNT  <= DIV_STALL_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;
    logic        stall, bubble_ex, ex_hold, div_busy;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_rd_valid, mem_rd_valid, wb_rd_valid, ex_is_load;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_stall_count, div_stall_count;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.DIV_CYCLES(4)) dut (
        .CLK(clk),
        .RESET(rst_n),
        .ID_INSTRUCTION(instr),
        .ID_VALID(id_valid),
        .FLUSH(flush),
        .STALL(stall),
        .BUBBLE_EX(bubble_ex),
        .EX_HOLD(ex_hold),
        .DIV_BUSY(div_busy),
        .EX_RD(ex_rd),
        .MEM_RD(mem_rd),
        .WB_RD(wb_rd),
        .EX_RD_VALID(ex_rd_valid),
        .MEM_RD_VALID(mem_rd_valid),
        .WB_RD_VALID(wb_rd_valid),
`ifdef HAZARD_PERF_CNT_EN
        .LOAD_STALL_COUNT(load_stall_count),
        .DIV_STALL_COUNT(div_stall_count),
`endif
        .EX_IS_LOAD(ex_is_load)
    );

    typedef struct packed {
        logic        st, bu, ho, by, ld;
        logic        exv;  logic [4:0] exr;
        logic        memv; logic [4:0] memr;
        logic        wbv;  logic [4:0] wbr;
        logic        pchk;
        logic [31:0] lsc, dsc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Slot arguments: -1 means invalid tag, otherwise the expected rd.
    function automatic exp_t o(input logic st, bu, ho, by, ld, input int ex, mem, wb);
        exp_t e;
        e      = '0;
        e.st   = st; e.bu = bu; e.ho = ho; e.by = by; e.ld = ld;
        e.exv  = (ex >= 0);  e.exr  = (ex >= 0)  ? 5'(ex)  : 5'd0;
        e.memv = (mem >= 0); e.memr = (mem >= 0) ? 5'(mem) : 5'd0;
        e.wbv  = (wb >= 0);  e.wbr  = (wb >= 0)  ? 5'(wb)  : 5'd0;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins, input logic v, input logic fl,
                        input exp_t e, input string nm,
                        input logic pchk = 1'b0, input int lsc = 0, input int dsc = 0);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n    = rst;
        instr    = ins;
        id_valid = v;
        flush    = fl;
        x        = e;
        x.pchk   = pchk;
        x.lsc    = 32'(lsc);
        x.dsc    = 32'(dsc);
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle is an output cycle; pop and compare on the falling edge.
    initial begin
        exp_t  e;
        string nm;
        logic  ok;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                ok = (stall === e.st) && (bubble_ex === e.bu) && (ex_hold === e.ho) &&
                     (div_busy === e.by) && (ex_is_load === e.ld) &&
                     (ex_rd_valid === e.exv) && (mem_rd_valid === e.memv) &&
                     (wb_rd_valid === e.wbv) &&
                     (!e.exv  || ex_rd  === e.exr) &&
                     (!e.memv || mem_rd === e.memr) &&
                     (!e.wbv  || wb_rd  === e.wbr);
                checks++;
                if (ok) passed++;
                else $display("FAIL %s: got st=%b bu=%b ho=%b by=%b ld=%b ex=%b/%0d mem=%b/%0d wb=%b/%0d, want st=%b bu=%b ho=%b by=%b ld=%b ex=%b/%0d mem=%b/%0d wb=%b/%0d",
                              nm, stall, bubble_ex, ex_hold, div_busy, ex_is_load,
                              ex_rd_valid, ex_rd, mem_rd_valid, mem_rd, wb_rd_valid, wb_rd,
                              e.st, e.bu, e.ho, e.by, e.ld, e.exv, e.exr, e.memv, e.memr, e.wbv, e.wbr);
`ifdef HAZARD_PERF_CNT_EN
                if (e.pchk) begin
                    checks++;
                    if (load_stall_count === e.lsc && div_stall_count === e.dsc) passed++;
                    else $display("FAIL %s_perf: got load=%0d div=%0d, want load=%0d div=%0d",
                                  nm, load_stall_count, div_stall_count, e.lsc, e.dsc);
                end
`endif
            end
        end
    end

    initial begin
        logic [31:0] addi3, addi4, addi7, addi11, lui0, lw5, lw0, add_dep, add_x0, div8, div12, sw5;
        int          waited;
        addi3   = i_type(12'd1, 5'd0, 3'd0, 5'd3, 7'b0010011);
        addi4   = i_type(12'd1, 5'd0, 3'd0, 5'd4, 7'b0010011);
        addi7   = i_type(12'd1, 5'd0, 3'd0, 5'd7, 7'b0010011);
        addi11  = i_type(12'd1, 5'd0, 3'd0, 5'd11, 7'b0010011);
        lui0    = {20'h12345, 5'd0, 7'b0110111};
        lw5     = i_type(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
        lw0     = i_type(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
        add_dep = r_type(7'd0, 5'd2, 5'd5, 3'd0, 5'd6);
        add_x0  = r_type(7'd0, 5'd2, 5'd0, 3'd0, 5'd6);
        div8    = r_type(7'b0000001, 5'd10, 5'd9, 3'b100, 5'd8);
        div12   = r_type(7'b0000001, 5'd10, 5'd9, 3'b100, 5'd12);
        sw5     = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};

        //   rst   instr    v     fl    expected st bu ho by ld  ex mem wb
        step(1'b0, '0,      1'b0, 1'b0, o(0,0,0,0,0, -1,-1,-1), "reset_a", 1'b1, 0, 0);
        step(1'b1, '0,      1'b0, 1'b0, o(0,0,0,0,0, -1,-1,-1), "reset_b");
        step(1'b1, addi3,   1'b1, 1'b0, o(0,0,0,0,0, -1,-1,-1), "tag_issue3");
        step(1'b1, addi4,   1'b1, 1'b0, o(0,0,0,0,0,  3,-1,-1), "tag_ex3");
        step(1'b1, addi7,   1'b1, 1'b0, o(0,0,0,0,0,  4, 3,-1), "tag_ex4");
        step(1'b1, lui0,    1'b1, 1'b0, o(0,0,0,0,0,  7, 4, 3), "tag_pipe_7_4_3");
        step(1'b1, lw5,     1'b1, 1'b0, o(0,0,0,0,0, -1, 7, 4), "lui_x0_invalid");
        step(1'b1, add_dep, 1'b1, 1'b0, o(1,1,0,0,1,  5,-1, 7), "load_use_stall");
        step(1'b1, add_dep, 1'b1, 1'b0, o(0,0,0,0,0, -1, 5,-1), "after_stall_bubble");
        step(1'b1, lw0,     1'b1, 1'b0, o(0,0,0,0,0,  6,-1, 5), "consumer_ex6");
        step(1'b1, add_x0,  1'b1, 1'b0, o(0,0,0,0,1, -1, 6,-1), "lw_x0_no_stall");
        step(1'b1, lw5,     1'b1, 1'b0, o(0,0,0,0,0,  6,-1, 6), "add_x0_issued");
        step(1'b1, add_dep, 1'b1, 1'b1, o(0,1,0,0,1,  5, 6,-1), "flush_over_load_use");
        step(1'b1, div8,    1'b1, 1'b1, o(0,1,0,0,0, -1, 5, 6), "flush_div_in_id");
        step(1'b1, div8,    1'b1, 1'b0, o(0,0,0,0,0, -1,-1, 5), "flush_no_divbusy");
        step(1'b1, addi11,  1'b1, 1'b0, o(1,0,1,1,0,  8,-1,-1), "div_hold_1");
        step(1'b1, addi11,  1'b1, 1'b0, o(1,0,1,1,0,  8,-1,-1), "div_hold_2");
        step(1'b1, addi11,  1'b1, 1'b0, o(1,0,1,1,0,  8,-1,-1), "div_hold_3");
        step(1'b1, addi11,  1'b1, 1'b0, o(0,0,0,1,0,  8,-1,-1), "div_last");
        step(1'b1, '0,      1'b0, 1'b0, o(0,0,0,0,0, 11, 8,-1), "div_to_mem");
        step(1'b1, lw5,     1'b1, 1'b0, o(0,0,0,0,0, -1,11, 8), "lw_again");
        step(1'b1, sw5,     1'b1, 1'b0, o(1,1,0,0,1,  5,-1,11), "store_rs2_stall");
        step(1'b1, sw5,     1'b1, 1'b0, o(0,0,0,0,0, -1, 5,-1), "store_issue");
        step(1'b1, '0,      1'b0, 1'b0, o(0,0,0,0,0, -1,-1, 5), "store_no_tag", 1'b1, 2, 3);
        step(1'b1, div12,   1'b1, 1'b0, o(0,0,0,0,0, -1,-1,-1), "div12_issue", 1'b1, 2, 3);
        step(1'b0, '0,      1'b0, 1'b0, o(1,0,1,1,0, 12,-1,-1), "div12_hold");
        step(1'b1, '0,      1'b0, 1'b0, o(0,0,0,0,0, -1,-1,-1), "reset_mid_div", 1'b1, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side companion to the forwarding unit in the RV32IM 5-stage pipeline.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB, and exports those tags to the forwarding logic.
- Generates load-use stalls and multicycle divide stalls, and inserts bubbles into ID/EX.
- Sits beside the decode stage; consumes the ID instruction and drives the pipeline-register enables.

Parameters:
- DIV_CYCLES, 32: cycles a DIV/DIVU/REM/REMU occupies EX; legal range 2..63.

Ports:
- CLK  input  1  pipeline clock
- RESET  input  1  synchronous, active-low reset
- ID_INSTRUCTION  input  32  instruction in ID
- ID_VALID  input  1  ID holds a real instruction
- FLUSH  input  1  branch/jump taken in EX; kills the instruction in ID
- STALL  output  1  hold PC and IF/ID
- BUBBLE_EX  output  1  load NOP into ID/EX this edge
- EX_HOLD  output  1  hold ID/EX contents (divide in progress)
- DIV_BUSY  output  1  divider occupying EX
- EX_RD, MEM_RD, WB_RD  output  5 each  tracked destination tags
- EX_RD_VALID, MEM_RD_VALID, WB_RD_VALID  output  1 each  tag valid (rd != 0, instruction writes rd)
- EX_IS_LOAD  output  1  EX slot is a load

Behaviour:
- Single clock. Reset is synchronous and active-low: when RESET is sampled low at a CLK edge, all three slots are invalid, all tags are 0, the state is IDLE and the counter is 0. All outputs are 0 on the following cycle.
- Decode from ID_INSTRUCTION[6:0]:
  - Uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Uses rs2: 0110011, 0100011, 1100011.
  - Writes rd: 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111.
  - Divide: opcode 0110011, funct7 0000001, funct3[2]=1.
- An instruction whose rd = x0 never creates a valid tag. A source register of x0 never causes a match.
- States: IDLE, DIV_BUSY. A load-use stall is a combinational condition in IDLE; it adds no extra state.
- IDLE, load-use condition: ID_VALID and EX_IS_LOAD and EX_RD_VALID and a used source equals EX_RD.
  - STALL=1 and BUBBLE_EX=1 for exactly that cycle.
  - At the edge: EX←bubble, MEM←EX, WB←MEM.
- IDLE, otherwise: STALL=0 and BUBBLE_EX=0.
  - At the edge: EX←ID decode (invalid if !ID_VALID), MEM←EX, WB←MEM.
  - If the ID instruction is a divide: next state DIV_BUSY, counter←DIV_CYCLES-1.
- FLUSH in IDLE:
  - Overrides the load-use condition: STALL=0 and BUBBLE_EX=1.
  - EX←bubble. No transition to DIV_BUSY, even if ID holds a divide.
  - MEM and WB shift normally.
- DIV_BUSY, counter != 0:
  - STALL=1, EX_HOLD=1, DIV_BUSY=1.
  - EX slot held. MEM←bubble, WB←MEM. Counter decrements.
- DIV_BUSY, counter == 0:
  - STALL=0, EX_HOLD=0, DIV_BUSY=1.
  - Normal IDLE-style shift, including load-use and divide checks on ID. Next state IDLE, unless ID holds a divide that is accepted, which reloads the counter and stays in DIV_BUSY.
- A divide therefore occupies EX for exactly DIV_CYCLES cycles.
- FLUSH is ignored in DIV_BUSY: no younger branch can be in EX while a divide is held there.
- Reset asserted mid-divide returns the block to IDLE at the next edge; the partial divide is abandoned.
- Back-to-back loads: the second load is checked against the first like any consumer.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, the block adds two outputs, LOAD_STALL_COUNT[31:0] and DIV_STALL_COUNT[31:0].
  - LOAD_STALL_COUNT increments on every load-use stall cycle.
  - DIV_STALL_COUNT increments on every cycle with EX_HOLD=1.
  - Both clear on reset and wrap from 0xFFFFFFFF to 0.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset: hold RESET low 2 cycles -> all outputs 0, all *_RD_VALID 0.
- Load-use: lw x5,0(x1), then add x6,x5,x2 in ID -> exactly one cycle with STALL=1 and BUBBLE_EX=1, then EX_RD=6. lw x0 followed by add x6,x0,x2 -> no stall.
- Tag pipeline: addi x3, addi x4, addi x7 issued back to back -> on cycle 3, EX_RD=7, MEM_RD=4, WB_RD=3, all valid. lui x0 -> EX_RD_VALID=0.
- Divide, DIV_CYCLES=4: div x8,x9,x10 accepted -> DIV_BUSY=1 for 4 cycles, STALL and EX_HOLD high for the first 3, MEM_RD_VALID=0 during the hold, then MEM_RD=8.
- Flush vs load-use: load in EX, dependent instruction in ID, FLUSH=1 -> STALL=0, BUBBLE_EX=1, next EX_RD_VALID=0. FLUSH with a divide in ID -> DIV_BUSY stays 0.
- With HAZARD_PERF_CNT_EN defined: two load-use stalls plus one DIV_CYCLES=4 divide -> LOAD_STALL_COUNT=2, DIV_STALL_COUNT=3.
